// File: rtl/fft_sram_pkg.sv
// fft_sram_pkg: shared types, limits and the parameter sanity check for the
// FFT working memory (fft_sram_bank and its sub-blocks).
package fft_sram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } sram_state_e;

    localparam int unsigned RD_LAT_MAX = 3;
    localparam int unsigned NPORT_MAX  = 4;
    localparam int unsigned COLL_CNT_W = 16;

    // True when a parameter set is one the bank can be built with.
    function automatic bit params_ok(
        input int unsigned data_w,
        input int unsigned depth,
        input int unsigned addr_w,
        input int unsigned nport,
        input int unsigned rd_lat
    );
        return (data_w >= 1) &&
               (depth >= 4) && ((depth & (depth - 1)) == 0) &&
               (addr_w == $clog2(depth)) &&
               (nport >= 1) && (nport <= NPORT_MAX) &&
               (rd_lat >= 1) && (rd_lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/fft_sram_bank_if.sv
// fft_sram_bank_if: read/write/clear bus of the FFT working memory.
//   master: drives i_* (clear, read enables/addresses, write enable/addresses/data)
//   slave : drives o_* (busy, read data/valids, collision flag and counter)
// Multi-port fields are packed, port p at [p*W +: W].
interface fft_sram_bank_if
    import fft_sram_pkg::*;
#(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned NPORT  = 2
);

    logic                    i_clear;
    logic                    o_busy;
    logic [NPORT-1:0]        i_re;
    logic [NPORT*ADDR_W-1:0] i_raddr;
    logic [NPORT*DATA_W-1:0] o_rdata;
    logic [NPORT-1:0]        o_rvalid;
    logic                    i_we;
    logic [NPORT*ADDR_W-1:0] i_waddr;
    logic [NPORT*DATA_W-1:0] i_wdata;
    logic                    o_collision;
    logic [COLL_CNT_W-1:0]   o_coll_cnt;

    modport master (
        output i_clear, i_re, i_raddr, i_we, i_waddr, i_wdata,
        input  o_busy, o_rdata, o_rvalid, o_collision, o_coll_cnt
    );

    modport slave (
        input  i_clear, i_re, i_raddr, i_we, i_waddr, i_wdata,
        output o_busy, o_rdata, o_rvalid, o_collision, o_coll_cnt
    );

endinterface

// File: rtl/fft_sram_rd_pipe.sv
// fft_sram_rd_pipe: per-port read data + valid delay line of STAGES registers.
//   clk, rst          : clock, synchronous active-high reset
//   d_valid, d_data   : first-stage read result
//   q_valid, q_data   : delayed result; q_data only advances with a valid word,
//                       so it holds the last read while no read is in flight
// STAGES = 0 is a plain wire-through.
module fft_sram_rd_pipe #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned STAGES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_valid,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data
);

    generate
        if (STAGES == 0) begin : g_thru
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q_valid        = d_valid;
            assign q_data         = d_data;
        end else begin : g_pipe
            logic [STAGES-1:0] v;
            logic [DATA_W-1:0] d [STAGES];

            // Valid shifts every cycle; data moves only behind a valid bit.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v <= '0;
                    for (int i = 0; i < int'(STAGES); i++) begin
                        d[i] <= '0;
                    end
                end else begin
                    v[0] <= d_valid;
                    if (d_valid) begin
                        d[0] <= d_data;
                    end
                    for (int i = 1; i < int'(STAGES); i++) begin
                        v[i] <= v[i-1];
                        if (v[i-1]) begin
                            d[i] <= d[i-1];
                        end
                    end
                end
            end

            assign q_valid = v[STAGES-1];
            assign q_data  = d[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/fft_sram_bank.sv
// fft_sram_bank: parametrised multi-port working memory for the FFT datapath.
//   clk      : single clock, rising edge
//   rst      : synchronous active-high reset (array contents are kept)
//   bus      : fft_sram_bank_if.slave
//              i_clear/o_busy          hardware clear, one word per cycle
//              i_re/i_raddr/o_rdata/o_rvalid  NPORT read ports, RD_LAT cycles
//              i_we/i_waddr/i_wdata    NPORT write ports under one enable
//              o_collision/o_coll_cnt  same-address write detection
// Writes to one address from several ports: highest port index wins.
// Build option: define FFT_SRAM_BYPASS_EN for write-first read-during-write
// (same-cycle write data, or zero for the word being cleared, is forwarded).
// Without it reads are read-first and there is no forwarding mux.
module fft_sram_bank
    import fft_sram_pkg::*;
#(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned NPORT  = 2,
    parameter int unsigned RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    fft_sram_bank_if.slave bus
);

    generate
        if (!params_ok(DATA_W, DEPTH, ADDR_W, NPORT, RD_LAT)) begin : g_param_check
            $error("fft_sram_bank: parameter set out of range");
        end
    endgenerate

    logic [DATA_W-1:0]     mem [DEPTH];

    sram_state_e           state;
    logic [ADDR_W-1:0]     clr_cnt;
    logic                  busy;
    logic                  collision;
    logic [COLL_CNT_W-1:0] coll_cnt;

    logic [ADDR_W-1:0]     raddr [NPORT];
    logic [ADDR_W-1:0]     waddr [NPORT];
    logic [DATA_W-1:0]     wdata [NPORT];
    logic [DATA_W-1:0]     rd_word_c [NPORT];
    logic                  wr_en_c;
    logic                  coll_c;

    logic [NPORT-1:0]      s0_valid;
    logic [DATA_W-1:0]     s0_data [NPORT];
    logic [NPORT-1:0]      pipe_valid;
    logic [DATA_W-1:0]     pipe_data [NPORT];
    logic [NPORT*DATA_W-1:0] rdata_flat;

    // Unpack the flat port buses.
    always_comb begin
        for (int p = 0; p < int'(NPORT); p++) begin
            raddr[p] = bus.i_raddr[p*ADDR_W +: ADDR_W];
            waddr[p] = bus.i_waddr[p*ADDR_W +: ADDR_W];
            wdata[p] = bus.i_wdata[p*DATA_W +: DATA_W];
        end
    end

    // User writes only land in IDLE and lose to a clear request in the same cycle.
    assign wr_en_c = bus.i_we && (state == IDLE) && !bus.i_clear && !rst;

    // Any pair of write ports on the same address.
    always_comb begin
        coll_c = 1'b0;
        for (int p = 0; p < int'(NPORT); p++) begin
            for (int q = p + 1; q < int'(NPORT); q++) begin
                if (waddr[p] == waddr[q]) begin
                    coll_c = 1'b1;
                end
            end
        end
        coll_c = coll_c && wr_en_c;
    end

    // Clear sequencer plus collision flag/counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            clr_cnt   <= '0;
            busy      <= 1'b0;
            collision <= 1'b0;
            coll_cnt  <= '0;
        end else begin
            collision <= coll_c;
            if (coll_c && (coll_cnt != {COLL_CNT_W{1'b1}})) begin
                coll_cnt <= coll_cnt + COLL_CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (bus.i_clear) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage array; the later loop iteration wins, giving the highest port priority.
    always_ff @(posedge clk) begin
        if (!rst && (state == CLEAR)) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en_c) begin
            for (int p = 0; p < int'(NPORT); p++) begin
                mem[waddr[p]] <= wdata[p];
            end
        end
    end

    // Array read, optionally overridden by this cycle's write.
    always_comb begin
        for (int p = 0; p < int'(NPORT); p++) begin
            rd_word_c[p] = mem[raddr[p]];
`ifdef FFT_SRAM_BYPASS_EN
            if (!rst && (state == CLEAR)) begin
                if (clr_cnt == raddr[p]) begin
                    rd_word_c[p] = '0;
                end
            end else if (wr_en_c) begin
                for (int q = 0; q < int'(NPORT); q++) begin
                    if (waddr[q] == raddr[p]) begin
                        rd_word_c[p] = wdata[q];
                    end
                end
            end
`endif
        end
    end

    // First read stage; data holds while the port is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid <= '0;
            for (int p = 0; p < int'(NPORT); p++) begin
                s0_data[p] <= '0;
            end
        end else begin
            s0_valid <= bus.i_re;
            for (int p = 0; p < int'(NPORT); p++) begin
                if (bus.i_re[p]) begin
                    s0_data[p] <= rd_word_c[p];
                end
            end
        end
    end

    generate
        for (genvar p = 0; p < int'(NPORT); p++) begin : g_port
            fft_sram_rd_pipe #(
                .DATA_W (DATA_W),
                .STAGES (RD_LAT - 1)
            ) u_rd_pipe (
                .clk     (clk),
                .rst     (rst),
                .d_valid (s0_valid[p]),
                .d_data  (s0_data[p]),
                .q_valid (pipe_valid[p]),
                .q_data  (pipe_data[p])
            );
        end
    endgenerate

    always_comb begin
        for (int p = 0; p < int'(NPORT); p++) begin
            rdata_flat[p*DATA_W +: DATA_W] = pipe_data[p];
        end
    end

    assign bus.o_rdata     = rdata_flat;
    assign bus.o_rvalid    = pipe_valid;
    assign bus.o_busy      = busy;
    assign bus.o_collision = collision;
    assign bus.o_coll_cnt  = coll_cnt;

endmodule

// File: tb/tb_fft_sram_bank.sv
// tb_fft_sram_bank: scoreboard bench for fft_sram_bank.
// dut_a: 128 x 256, 2 ports, RD_LAT=1 (clear, collision, read-during-write, reset).
// dut_b: 32 x 16, 4 ports, RD_LAT=3 (back-to-back latency sweep).
module tb_fft_sram_bank;

    localparam int unsigned DW_A  = 128;
    localparam int unsigned DEP_A = 256;
    localparam int unsigned AW_A  = 8;
    localparam int unsigned NP_A  = 2;
    localparam int unsigned LAT_A = 1;
    localparam int unsigned DW_B  = 32;
    localparam int unsigned DEP_B = 16;
    localparam int unsigned AW_B  = 4;
    localparam int unsigned NP_B  = 4;
    localparam int unsigned LAT_B = 3;

    typedef struct {
        int           due;
        int           port;
        logic [127:0] data;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    int   busy_seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_sram_bank_if #(.DATA_W(DW_A), .DEPTH(DEP_A), .ADDR_W(AW_A), .NPORT(NP_A)) bus_a ();
    fft_sram_bank_if #(.DATA_W(DW_B), .DEPTH(DEP_B), .ADDR_W(AW_B), .NPORT(NP_B)) bus_b ();

    fft_sram_bank #(.DATA_W(DW_A), .DEPTH(DEP_A), .ADDR_W(AW_A), .NPORT(NP_A), .RD_LAT(LAT_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    fft_sram_bank #(.DATA_W(DW_B), .DEPTH(DEP_B), .ADDR_W(AW_B), .NPORT(NP_B), .RD_LAT(LAT_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // Reference state.
    logic [127:0] ma [DEP_A];
    bit           m_clear = 1'b0;
    int           m_cnt = 0;
    bit           m_coll = 1'b0;
    int           m_ccnt = 0;
    logic [31:0]  mb [DEP_B];
    rd_exp_t      qa[$];
    rd_exp_t      qb[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One cycle of stimulus on dut_a; the model advances to the state after the next edge.
    task automatic drive_a(input logic [1:0] re, input logic [7:0] ra0, input logic [7:0] ra1,
                           input logic we, input logic [7:0] wa0, input logic [7:0] wa1,
                           input logic [127:0] wd0, input logic [127:0] wd1,
                           input logic clr, input logic rs);
        logic [7:0]   ra [2];
        logic [7:0]   wa [2];
        logic [127:0] wd [2];
        logic [127:0] d;
        bit           wr_ok;
        rd_exp_t      e;
        @(posedge clk);
        #1;
        if (mon_en) begin
            check("a_busy", 128'(bus_a.o_busy), 128'(m_clear));
            check("a_collision", 128'(bus_a.o_collision), 128'(m_coll));
            check("a_coll_cnt", 128'(bus_a.o_coll_cnt), 128'(m_ccnt));
        end
        if (bus_a.o_busy === 1'b1) busy_seen++;
        rst           = rs;
        bus_a.i_re    = re;
        bus_a.i_raddr = {ra1, ra0};
        bus_a.i_we    = we;
        bus_a.i_waddr = {wa1, wa0};
        bus_a.i_wdata = {wd1, wd0};
        bus_a.i_clear = clr;
        if (rs) begin
            m_clear = 1'b0;
            m_cnt   = 0;
            m_coll  = 1'b0;
            m_ccnt  = 0;
            return;
        end
        ra[0] = ra0; ra[1] = ra1;
        wa[0] = wa0; wa[1] = wa1;
        wd[0] = wd0; wd[1] = wd1;
        wr_ok = we && !m_clear && !clr;
        for (int p = 0; p < 2; p++) begin
            if (re[p]) begin
                d = ma[ra[p]];
`ifdef FFT_SRAM_BYPASS_EN
                if (m_clear) begin
                    if (m_cnt == int'(ra[p])) d = '0;
                end else if (wr_ok) begin
                    for (int q = 0; q < 2; q++) if (wa[q] == ra[p]) d = wd[q];
                end
`endif
                e.due  = cyc + int'(LAT_A);
                e.port = p;
                e.data = d;
                qa.push_back(e);
            end
        end
        m_coll = wr_ok && (wa0 == wa1);
        if (m_coll && m_ccnt < 65535) m_ccnt++;
        if (m_clear) begin
            ma[m_cnt] = '0;
            if (m_cnt == int'(DEP_A) - 1) m_clear = 1'b0;
            m_cnt++;
        end else if (clr) begin
            m_clear = 1'b1;
            m_cnt   = 0;
        end else if (wr_ok) begin
            ma[wa0] = wd0;
            ma[wa1] = wd1;
        end
    endtask

    task automatic idle_a(input int n);
        repeat (n) drive_a(2'b00, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic drive_b(input logic [3:0] re, input logic [15:0] ra, input logic we,
                           input logic [15:0] wa, input logic [127:0] wd);
        rd_exp_t e;
        @(posedge clk);
        #1;
        if (mon_en) check("b_collision", 128'(bus_b.o_collision), '0);
        bus_b.i_re    = re;
        bus_b.i_raddr = ra;
        bus_b.i_we    = we;
        bus_b.i_waddr = wa;
        bus_b.i_wdata = wd;
        for (int p = 0; p < int'(NP_B); p++) begin
            if (re[p]) begin
                e.due  = cyc + int'(LAT_B);
                e.port = p;
                e.data = 128'(mb[ra[p*4 +: 4]]);
                qb.push_back(e);
            end
        end
        if (we) for (int p = 0; p < int'(NP_B); p++) mb[wa[p*4 +: 4]] = wd[p*32 +: 32];
    endtask

    // Read-side scoreboard: every port checked every cycle for valid, data on valid.
    always @(negedge clk) begin
        logic ev;
        if (mon_en) begin
            for (int p = 0; p < int'(NP_A); p++) begin
                ev = (qa.size() > 0) && (qa[0].due == cyc) && (qa[0].port == p);
                check($sformatf("a_rvalid%0d", p), 128'(bus_a.o_rvalid[p]), 128'(ev));
                if (ev) begin
                    check($sformatf("a_rdata%0d", p), 128'(bus_a.o_rdata[p*DW_A +: DW_A]), qa[0].data);
                    void'(qa.pop_front());
                end
            end
            if ((qa.size() > 0) && (qa[0].due < cyc)) begin
                check("a_late", 128'(qa[0].due), 128'(cyc));
                void'(qa.pop_front());
            end
            for (int p = 0; p < int'(NP_B); p++) begin
                ev = (qb.size() > 0) && (qb[0].due == cyc) && (qb[0].port == p);
                check($sformatf("b_rvalid%0d", p), 128'(bus_b.o_rvalid[p]), 128'(ev));
                if (ev) begin
                    check($sformatf("b_rdata%0d", p), 128'(bus_b.o_rdata[p*DW_B +: DW_B]), qb[0].data);
                    void'(qb.pop_front());
                end
            end
            if ((qb.size() > 0) && (qb[0].due < cyc)) begin
                check("b_late", 128'(qb[0].due), 128'(cyc));
                void'(qb.pop_front());
            end
        end
    end

    initial begin
        logic [15:0]  bra;
        logic [15:0]  bwa;
        logic [127:0] bwd;
        for (int i = 0; i < int'(DEP_A); i++) ma[i] = '0;
        for (int i = 0; i < int'(DEP_B); i++) mb[i] = '0;
        bus_a.i_re = '0; bus_a.i_raddr = '0; bus_a.i_we = 1'b0;
        bus_a.i_waddr = '0; bus_a.i_wdata = '0; bus_a.i_clear = 1'b0;
        bus_b.i_re = '0; bus_b.i_raddr = '0; bus_b.i_we = 1'b0;
        bus_b.i_waddr = '0; bus_b.i_wdata = '0; bus_b.i_clear = 1'b0;
        repeat (2) @(posedge clk);
        drive_a(2'b00, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, '0, '0, 1'b0, 1'b1);
        idle_a(1);
        mon_en = 1'b1;

        // Full clear; a both-port write to addr 9 mid-clear is dropped.
        busy_seen = 0;
        drive_a(2'b00, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 260; i++) begin
            if (i == 50) drive_a(2'b00, 8'd0, 8'd0, 1'b1, 8'd9, 8'd9, 128'hDEAD, 128'hBEEF, 1'b0, 1'b0);
            else idle_a(1);
        end
        check("busy_len", 128'(busy_seen), 128'(256));
        for (int i = 0; i < 128; i++)
            drive_a(2'b11, 8'(i), 8'(255 - i), 1'b0, 8'd0, 8'd0, '0, '0, 1'b0, 1'b0);
        idle_a(3);

        // Single read, then hold while idle.
        drive_a(2'b00, 8'd0, 8'd0, 1'b1, 8'd5, 8'd6, {16{8'hA5}}, 128'h66, 1'b0, 1'b0);
        drive_a(2'b01, 8'd5, 8'd0, 1'b0, 8'd0, 8'd0, '0, '0, 1'b0, 1'b0);
        idle_a(3);
        check("a_hold", bus_a.o_rdata[127:0], {16{8'hA5}});

        // Collision on addr 17, port 1 wins.
        drive_a(2'b00, 8'd0, 8'd0, 1'b1, 8'd17, 8'd17, 128'h1, 128'h2, 1'b0, 1'b0);
        idle_a(1);
        drive_a(2'b11, 8'd17, 8'd17, 1'b0, 8'd0, 8'd0, '0, '0, 1'b0, 1'b0);
        idle_a(2);

        // Read-during-write on addr 3, then a colliding write read in the same cycle.
        drive_a(2'b00, 8'd0, 8'd0, 1'b1, 8'd3, 8'd4, 128'hFF, 128'h44, 1'b0, 1'b0);
        drive_a(2'b01, 8'd3, 8'd0, 1'b1, 8'd3, 8'd4, 128'h7, 128'h45, 1'b0, 1'b0);
        drive_a(2'b01, 8'd3, 8'd0, 1'b0, 8'd0, 8'd0, '0, '0, 1'b0, 1'b0);
        drive_a(2'b11, 8'd20, 8'd20, 1'b1, 8'd20, 8'd20, 128'hA, 128'hB, 1'b0, 1'b0);
        drive_a(2'b10, 8'd0, 8'd20, 1'b0, 8'd0, 8'd0, '0, '0, 1'b0, 1'b0);
        idle_a(2);

        // Reset in the middle of a clear; clear+write in one cycle drops the write.
        drive_a(2'b00, 8'd0, 8'd0, 1'b1, 8'd200, 8'd50, 128'hC8C8, 128'h3232, 1'b0, 1'b0);
        drive_a(2'b00, 8'd0, 8'd0, 1'b1, 8'd40, 8'd41, 128'h4040, 128'h4141, 1'b0, 1'b0);
        drive_a(2'b00, 8'd0, 8'd0, 1'b1, 8'd250, 8'd251, 128'hFAFA, 128'hFBFB, 1'b0, 1'b0);
        drive_a(2'b00, 8'd0, 8'd0, 1'b1, 8'd250, 8'd251, 128'h1111, 128'h2222, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (i == 20) drive_a(2'b11, 8'd200, 8'd250, 1'b0, 8'd0, 8'd0, '0, '0, 1'b0, 1'b0);
            else if (m_clear && m_cnt == 40)
                drive_a(2'b01, 8'd40, 8'd0, 1'b0, 8'd0, 8'd0, '0, '0, 1'b0, 1'b0);
            else idle_a(1);
        end
        drive_a(2'b00, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, '0, '0, 1'b0, 1'b1);
        idle_a(1);
        drive_a(2'b11, 8'd50, 8'd200, 1'b0, 8'd0, 8'd0, '0, '0, 1'b0, 1'b0);
        drive_a(2'b11, 8'd250, 8'd251, 1'b0, 8'd0, 8'd0, '0, '0, 1'b0, 1'b0);
        idle_a(3);

        // dut_b: fill all 16 words, then reads on all four ports every cycle.
        for (int c = 0; c < 4; c++) begin
            for (int p = 0; p < 4; p++) begin
                bwa[p*4 +: 4]   = 4'(c * 4 + p);
                bwd[p*32 +: 32] = $urandom;
            end
            drive_b(4'h0, 16'h0, 1'b1, bwa, bwd);
        end
        for (int i = 0; i < 24; i++) begin
            for (int p = 0; p < 4; p++) bra[p*4 +: 4] = 4'($urandom_range(15, 0));
            drive_b(4'hF, bra, 1'b0, 16'h0, '0);
        end
        repeat (6) drive_b(4'h0, 16'h0, 1'b0, 16'h0, '0);

        check("a_pending", 128'(qa.size()), '0);
        check("b_pending", 128'(qb.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
